kitchen_order_scheduler: RTL and testbench
==========================================

// Module: kitchen_order_scheduler
// PURPOSE
// - Shares one kitchen (single cook station) among N_TABLES tables that place orders.
// - Round-robin arbitrates order requests into an order queue (FIFO).
// - Sequences each queued order through a timed COOK phase and a SERVE handshake with the waiter.
// - Sits upstream of the per-order restaurant FSMs and drives their state.
// PARAMETERS
// - N_TABLES    = 4 : number of requesting tables, >= 2
// - QUEUE_DEPTH = 4 : order FIFO entries, power of 2, >= 2
// - COOK_CYCLES = 8 : cycles spent in COOK per order, >= 1
// - TW = $clog2(N_TABLES) : table index width (localparam)
// PORTS
// - clk          in   1         : clock, all logic on rising edge
// - reset        in   1         : synchronous, active-low reset
// - order_req    in   N_TABLES  : per-table order request, level, held until acked
// - order_ack    out  N_TABLES  : one-hot, 1-cycle pulse, order accepted into queue
// - serve_valid  out  1         : meal for serve_table is ready to carry out
// - serve_table  out  TW        : table index of the meal in COOK/SERVE
// - serve_done   in   1         : waiter has delivered the meal; sampled only in SERVE
// - state_out    out  2         : 2'b00 IDLE, 2'b01 COOK, 2'b10 SERVE; 2'b11 never driven
// - queue_count  out  TW'($clog2(QUEUE_DEPTH)+1) : orders waiting in the FIFO
// - queue_full   out  1         : queue_count == QUEUE_DEPTH
// BEHAVIOUR
// - Reset: edge with reset==0 clears FIFO, pointers and counters.
//   - All outputs 0; state IDLE; round-robin pointer = table 0.
//   - Reset mid-COOK/SERVE aborts the order; the order is lost.
// - Arbitration (enqueue):
//   - eligible = order_req & ~order_ack.
//   - Grant the first eligible table at or after rr_ptr (wrapping).
//   - Enqueue only if the registered queue_count < QUEUE_DEPTH.
//   - On grant: write index at tail, order_ack[g] = 1 next cycle, rr_ptr = g+1 mod N_TABLES.
//   - Full: no grant, no ack, rr_ptr unchanged; requests stay pending.
//   - Max one enqueue per cycle.
// - Kitchen FSM (dequeue):
//   - IDLE: if queue_count > 0, pop head into serve_table, load cook_cnt = COOK_CYCLES-1, go COOK.
//   - COOK: if cook_cnt == 0 go SERVE, else decrement.
//     - COOK lasts exactly COOK_CYCLES cycles.
//   - SERVE: serve_valid = 1.
//     - serve_done=1 with queue_count>0: pop next order and go COOK directly (no IDLE bubble).
//     - serve_done=1 with empty queue: go IDLE.
//   - serve_done outside SERVE is ignored.
// - Simultaneous enqueue and pop on the same edge:
//   - queue_count unchanged.
//   - Full-check uses the pre-edge count, so a full queue that pops this edge still refuses the request.
// - Empty FIFO with an enqueue on edge k: pop on edge k+1 (no bypass).
// - Pointers wrap modulo QUEUE_DEPTH.
// - serve_table holds its value in IDLE until the next pop.
// CONFIGURATION
// - `KITCHEN_STATS_EN` defined:
//   - Adds output served_count[15:0].
//   - Increments on each SERVE exit via serve_done; saturates at 16'hFFFF; reset to 0.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING
// - Reset: drive reset=0 with all req=1 -> all outputs 0, state_out=00, no ack while reset low.
// - Single order: req[2]=1 at edge0.
//   - order_ack=4'b0100 for one cycle; state_out=01 from edge1 for 8 cycles, then 10 with serve_table=2.
//   - serve_done=1 -> 00.
// - Round-robin: req=4'b1111 held, kitchen stalled in SERVE -> acks in order tables 0,1,2,3.
//   - queue_full=1 after the 4th; no 5th ack until a pop.
// - Back-to-back: 2 queued orders, serve_done in SERVE -> direct SERVE->COOK.
//   - Next serve_table = second order; queue_count decrements.
// - Full + pop same edge: queue full and serve_done=1 with req pending.
//   - Pop happens, no ack that edge; ack on the following edge.
// - Stats (KITCHEN_STATS_EN): serve 3 orders -> served_count=3; mid-COOK reset -> 0.

Source files
------------

// File: rtl/kitchen_order_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : kitchen_order_scheduler
// Description : Round-robin order intake into a FIFO, feeding one cook
//               station that runs a timed COOK phase and a waiter SERVE
//               handshake. Optional served-meal counter: KITCHEN_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module kitchen_order_scheduler #(
   parameter int N_TABLES    = 4,
   parameter int QUEUE_DEPTH = 4,
   parameter int COOK_CYCLES = 8,
   localparam int TW = $clog2(N_TABLES),
   localparam int CW = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_TABLES-1:0] order_req,
   output logic [N_TABLES-1:0] order_ack,
   output logic                serve_valid,
   output logic [TW-1:0]       serve_table,
   input  logic                serve_done,
   output logic [1:0]          state_out,
   output logic [CW-1:0]       queue_count,
`ifdef KITCHEN_STATS_EN
   output logic [15:0]         served_count,
`endif
   output logic                queue_full
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int KW = $clog2(COOK_CYCLES + 1);

   localparam logic [CW-1:0] C_DEPTH     = CW'(QUEUE_DEPTH);
   localparam logic [KW-1:0] C_COOK_INIT = KW'(COOK_CYCLES - 1);
   localparam logic [TW-1:0] C_LAST_TBL  = TW'(N_TABLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COOK  = 2'b01,
      ST_SERVE = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [KW-1:0]       cook_cnt_q, cook_cnt_d;
   logic [TW-1:0]       serve_table_q, serve_table_d;
   logic [TW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [N_TABLES-1:0] order_ack_q, order_ack_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [TW-1:0]       mem_q [QUEUE_DEPTH];
   logic [TW-1:0]       mem_d [QUEUE_DEPTH];
`ifdef KITCHEN_STATS_EN
   logic [15:0]         served_q, served_d;
`endif

   logic [N_TABLES-1:0] eligible;
   logic                grant_found;
   logic [TW-1:0]       grant_idx;
   logic                enq;
   logic                pop;
   logic                serve_exit;

   // A table still showing its ack this cycle is masked so it cannot be granted twice.
   always_comb begin
      int cand;
      cand        = 0;
      eligible    = order_req & ~order_ack_q;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < N_TABLES; i++) begin
         cand = (int'(rr_ptr_q) + i) % N_TABLES;
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = TW'(cand);
         end
      end
      enq = grant_found && (count_q < C_DEPTH);
   end

   always_comb begin
      state_d       = state_q;
      cook_cnt_d    = cook_cnt_q;
      serve_table_d = serve_table_q;
      pop           = 1'b0;
      serve_exit    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop        = 1'b1;
               state_d    = ST_COOK;
               cook_cnt_d = C_COOK_INIT;
            end
         end
         ST_COOK: begin
            if (cook_cnt_q == '0) begin
               state_d = ST_SERVE;
            end else begin
               cook_cnt_d = cook_cnt_q - 1'b1;
            end
         end
         ST_SERVE: begin
            if (serve_done) begin
               serve_exit = 1'b1;
               if (count_q != '0) begin
                  pop        = 1'b1;
                  state_d    = ST_COOK;
                  cook_cnt_d = C_COOK_INIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         serve_table_d = mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rr_ptr_d    = rr_ptr_q;
      order_ack_d = '0;
      if (enq) begin
         mem_d[wr_ptr_q]        = grant_idx;
         wr_ptr_d               = wr_ptr_q + 1'b1;
         order_ack_d[grant_idx] = 1'b1;
         rr_ptr_d               = (grant_idx == C_LAST_TBL) ? '0 : grant_idx + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({enq, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

`ifdef KITCHEN_STATS_EN
   always_comb begin
      served_d = served_q;
      if (serve_exit && (served_q != 16'hFFFF)) begin
         served_d = served_q + 16'd1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cook_cnt_q    <= '0;
         serve_table_q <= '0;
         rr_ptr_q      <= '0;
         order_ack_q   <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef KITCHEN_STATS_EN
         served_q      <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cook_cnt_q    <= cook_cnt_d;
         serve_table_q <= serve_table_d;
         rr_ptr_q      <= rr_ptr_d;
         order_ack_q   <= order_ack_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
`ifdef KITCHEN_STATS_EN
         served_q      <= served_d;
`endif
      end
   end

   assign order_ack   = order_ack_q;
   assign serve_valid = (state_q == ST_SERVE);
   assign serve_table = serve_table_q;
   assign state_out   = state_q;
   assign queue_count = count_q;
   assign queue_full  = (count_q == C_DEPTH);
`ifdef KITCHEN_STATS_EN
   assign served_count = served_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kitchen_order_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_kitchen_order_scheduler
// Description : Directed self-checking bench for kitchen_order_scheduler
//               (default parameters: 4 tables, 4-deep queue, 8 cook cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kitchen_order_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] order_req;
   logic [3:0] order_ack;
   logic       serve_valid;
   logic [1:0] serve_table;
   logic       serve_done;
   logic [1:0] state_out;
   logic [2:0] queue_count;
   logic       queue_full;
`ifdef KITCHEN_STATS_EN
   logic [15:0] served_count;
`endif

   int checks   = 0;
   int failures = 0;

   kitchen_order_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .order_req   (order_req),
      .order_ack   (order_ack),
      .serve_valid (serve_valid),
      .serve_table (serve_table),
      .serve_done  (serve_done),
      .state_out   (state_out),
      .queue_count (queue_count),
`ifdef KITCHEN_STATS_EN
      .served_count(served_count),
`endif
      .queue_full  (queue_full)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b0;
      order_req  = 4'b1111;
      serve_done = 1'b0;
      repeat (3) tick();
      check("rst_ack",   32'(order_ack),   32'h0);
      check("rst_state", 32'(state_out),   32'h0);
      check("rst_valid", 32'(serve_valid), 32'h0);
      check("rst_count", 32'(queue_count), 32'h0);
      check("rst_full",  32'(queue_full),  32'h0);
      check("rst_table", 32'(serve_table), 32'h0);
`ifdef KITCHEN_STATS_EN
      check("rst_served", 32'(served_count), 32'h0);
`endif

      // Single order from table 2
      reset     = 1'b1;
      order_req = 4'b0100;
      tick();
      check("single_ack",   32'(order_ack),   32'h4);
      check("single_count", 32'(queue_count), 32'h1);
      check("single_idle",  32'(state_out),   32'h0);
      order_req = 4'b0000;
      tick();
      check("single_ack_pulse", 32'(order_ack),   32'h0);
      check("single_cook",      32'(state_out),   32'h1);
      check("single_table",     32'(serve_table), 32'h2);
      check("single_pop_count", 32'(queue_count), 32'h0);
      check("cook_no_valid",    32'(serve_valid), 32'h0);
      repeat (7) tick();
      check("cook_8th_cycle", 32'(state_out), 32'h1);
      tick();
      check("serve_state", 32'(state_out),   32'h2);
      check("serve_valid", 32'(serve_valid), 32'h1);
      check("serve_table", 32'(serve_table), 32'h2);
      serve_done = 1'b1;
      tick();
      serve_done = 1'b0;
      check("serve_to_idle",  32'(state_out),   32'h0);
      check("idle_valid",     32'(serve_valid), 32'h0);
      check("idle_hold_tbl",  32'(serve_table), 32'h2);

      // Table 3 takes the kitchen into SERVE; pointer then wraps to table 0
      order_req = 4'b1000;
      tick();
      check("t3_ack", 32'(order_ack), 32'h8);
      order_req = 4'b0000;
      tick();
      check("t3_cook",  32'(state_out),   32'h1);
      check("t3_table", 32'(serve_table), 32'h3);
      repeat (8) tick();
      check("t3_serve", 32'(state_out), 32'h2);

      // Round-robin fill while the kitchen is stalled in SERVE
      order_req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rr_ack%0d", i),   32'(order_ack),   32'(1 << i));
         check($sformatf("rr_count%0d", i), 32'(queue_count), 32'(i + 1));
      end
      check("rr_full", 32'(queue_full), 32'h1);
      tick();
      check("full_no_ack",    32'(order_ack),   32'h0);
      check("full_count",     32'(queue_count), 32'h4);
      check("full_stall_srv", 32'(state_out),   32'h2);

      // Full queue and serve_done on the same edge: pop, no ack
      serve_done = 1'b1;
      tick();
      serve_done = 1'b0;
      check("fp_direct_cook", 32'(state_out),   32'h1);
      check("fp_next_table",  32'(serve_table), 32'h0);
      check("fp_no_ack",      32'(order_ack),   32'h0);
      check("fp_count",       32'(queue_count), 32'h3);
      check("fp_not_full",    32'(queue_full),  32'h0);
      tick();
      check("fp_late_ack",   32'(order_ack),   32'h1);
      check("fp_refill",     32'(queue_count), 32'h4);
      order_req = 4'b0000;
      repeat (7) tick();
      check("b2b_serve", 32'(state_out),   32'h2);
      check("b2b_table", 32'(serve_table), 32'h0);

      // Back-to-back SERVE -> COOK with next queued order (table 1)
      serve_done = 1'b1;
      tick();
      check("b2b_cook",      32'(state_out),   32'h1);
      check("b2b_tbl_next",  32'(serve_table), 32'h1);
      check("b2b_count",     32'(queue_count), 32'h3);
`ifdef KITCHEN_STATS_EN
      check("stats_three", 32'(served_count), 32'h3);
`endif
      tick();
      serve_done = 1'b0;
      check("done_ignored_cook", 32'(state_out),   32'h1);
      check("done_ignored_cnt",  32'(queue_count), 32'h3);
`ifdef KITCHEN_STATS_EN
      check("stats_ignore_cook", 32'(served_count), 32'h3);
`endif

      // Reset mid-COOK drops everything
      reset = 1'b0;
      tick();
      check("midrst_state", 32'(state_out),   32'h0);
      check("midrst_count", 32'(queue_count), 32'h0);
      check("midrst_table", 32'(serve_table), 32'h0);
      check("midrst_valid", 32'(serve_valid), 32'h0);
`ifdef KITCHEN_STATS_EN
      check("midrst_served", 32'(served_count), 32'h0);
`endif
      reset = 1'b1;
      tick();
      check("post_rst_idle", 32'(state_out), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
